// File: rtl/uram_read_arbiter_if.sv
// rtl/uram_read_arbiter_if.sv - request/response/URAM port bundle for uram_read_arbiter
//
// Groups the two requester channels, the URAM read port, pause and busy.
//   slave  : the arbiter side (takes requests, drives URAM read, returns data)
//   master : the environment side (requesters plus the URAM itself)
// Signals:
//   pause                      stop new grants, in-flight reads drain
//   req{0,1}_valid/addr/ready  read request handshake per requester
//   rsp{0,1}_valid/data        one-cycle response pulse with returned word
//   rd_uram/rd_addr            registered URAM read enable and address
//   data_uram                  URAM read data, RD_LAT cycles after rd_uram
//   busy                       reads in flight or a response pulse this cycle
interface uram_read_arbiter_if #(
  parameter int WIDTH     = 3072,
  parameter int URAM_ADDR = 12
);
  logic                 pause;
  logic                 req0_valid;
  logic [URAM_ADDR-1:0] req0_addr;
  logic                 req0_ready;
  logic                 rsp0_valid;
  logic [WIDTH-1:0]     rsp0_data;
  logic                 req1_valid;
  logic [URAM_ADDR-1:0] req1_addr;
  logic                 req1_ready;
  logic                 rsp1_valid;
  logic [WIDTH-1:0]     rsp1_data;
  logic                 rd_uram;
  logic [URAM_ADDR-1:0] rd_addr;
  logic [WIDTH-1:0]     data_uram;
  logic                 busy;

  modport slave (
    input  pause,
    input  req0_valid, req0_addr, req1_valid, req1_addr,
    output req0_ready, rsp0_valid, rsp0_data,
    output req1_ready, rsp1_valid, rsp1_data,
    output rd_uram, rd_addr,
    input  data_uram,
    output busy
  );

  modport master (
    output pause,
    output req0_valid, req0_addr, req1_valid, req1_addr,
    input  req0_ready, rsp0_valid, rsp0_data,
    input  req1_ready, rsp1_valid, rsp1_data,
    input  rd_uram, rd_addr,
    output data_uram,
    input  busy
  );
endinterface

// File: rtl/uram_read_arbiter.sv
// rtl/uram_read_arbiter.sv - round-robin sharing of one URAM read port between two requesters
//
// Grants at most one request per cycle (round-robin on contention), issues a
// registered URAM read, and steers the returned word to the issuing requester
// using a {valid,id} tag pipeline matched to the URAM read latency.
// Ports:
//   clk  rising-edge clock
//   rst  synchronous active-high reset
//   bus  uram_read_arbiter_if.slave (requests, responses, URAM port, pause, busy)
module uram_read_arbiter #(
  parameter int WIDTH     = 3072,
  parameter int URAM_ADDR = 12,
  parameter int RD_LAT    = 2
) (
  input logic                clk,
  input logic                rst,
  uram_read_arbiter_if.slave bus
);

  // One stage per cycle from accept until the data beat on data_uram.
  localparam int STAGES = RD_LAT + 1;

  logic                 last_grant;
  logic                 grant0;
  logic                 grant1;
  logic                 accept;
  logic [STAGES-1:0]    tag_valid;
  logic [STAGES-1:0]    tag_id;
  logic                 rd_uram_q;
  logic [URAM_ADDR-1:0] rd_addr_q;
  logic                 rsp0_valid_q;
  logic                 rsp1_valid_q;
  logic [WIDTH-1:0]     rsp0_data_q;
  logic [WIDTH-1:0]     rsp1_data_q;
  logic                 tag_out_valid;
  logic                 tag_out_id;

  // On contention the requester that did not win last time goes next.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (!rst && !bus.pause) begin
      if (bus.req0_valid && bus.req1_valid) begin
        grant0 = last_grant;
        grant1 = !last_grant;
      end else begin
        grant0 = bus.req0_valid;
        grant1 = bus.req1_valid;
      end
    end
  end

  assign accept        = grant0 | grant1;
  assign tag_out_valid = tag_valid[STAGES-1];
  assign tag_out_id    = tag_id[STAGES-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant   <= 1'b1;
      rd_uram_q    <= 1'b0;
      rd_addr_q    <= '0;
      tag_valid    <= '0;
      tag_id       <= '0;
      rsp0_valid_q <= 1'b0;
      rsp1_valid_q <= 1'b0;
      rsp0_data_q  <= '0;
      rsp1_data_q  <= '0;
    end else begin
      rd_uram_q <= accept;
      if (accept) begin
        rd_addr_q  <= grant0 ? bus.req0_addr : bus.req1_addr;
        last_grant <= grant1;
      end
      // Tags shift every cycle; the last stage lines up with data_uram.
      tag_valid    <= {tag_valid[STAGES-2:0], accept};
      tag_id       <= {tag_id[STAGES-2:0], grant1};
      rsp0_valid_q <= tag_out_valid && !tag_out_id;
      rsp1_valid_q <= tag_out_valid && tag_out_id;
      if (tag_out_valid && !tag_out_id) rsp0_data_q <= bus.data_uram;
      if (tag_out_valid && tag_out_id)  rsp1_data_q <= bus.data_uram;
    end
  end

  assign bus.req0_ready = grant0;
  assign bus.req1_ready = grant1;
  assign bus.rd_uram    = rd_uram_q;
  assign bus.rd_addr    = rd_addr_q;
  assign bus.rsp0_valid = rsp0_valid_q;
  assign bus.rsp1_valid = rsp1_valid_q;
  assign bus.rsp0_data  = rsp0_data_q;
  assign bus.rsp1_data  = rsp1_data_q;
  assign bus.busy       = (|tag_valid) | rsp0_valid_q | rsp1_valid_q;

endmodule

// File: tb/tb_uram_read_arbiter.sv
// tb/tb_uram_read_arbiter.sv - self-checking bench for uram_read_arbiter
//
// Drives two requesters and a behavioural URAM through the interface, logs
// grants, URAM reads and responses each cycle, and checks them against
// expectations derived from the arbitration and latency rules.
module tb_uram_read_arbiter;
  localparam int WIDTH     = 3072;
  localparam int URAM_ADDR = 12;
  localparam int RD_LAT    = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  uram_read_arbiter_if #(.WIDTH(WIDTH), .URAM_ADDR(URAM_ADDR)) bus ();

  uram_read_arbiter #(.WIDTH(WIDTH), .URAM_ADDR(URAM_ADDR), .RD_LAT(RD_LAT)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  logic [31:0] mem_salt = 32'h1234_5678;

  always @(posedge clk) cyc <= cyc + 1;

  // URAM contents: a deterministic word per address, varied by a salt.
  function automatic logic [WIDTH-1:0] mem_word(input logic [URAM_ADDR-1:0] a, input logic [31:0] salt);
    logic [WIDTH-1:0] w;
    for (int i = 0; i < WIDTH / 32; i++)
      w[i*32 +: 32] = (32'(a) * 32'h9E37_79B1) ^ salt ^ 32'(i);
    return w;
  endfunction

  // URAM read port: data valid RD_LAT cycles after rd_uram is sampled.
  logic [RD_LAT-1:0]    pv = '0;
  logic [URAM_ADDR-1:0] pa [RD_LAT];
  always @(posedge clk) begin
    for (int i = RD_LAT - 1; i > 0; i--) begin
      pv[i] <= pv[i-1];
      pa[i] <= pa[i-1];
    end
    pv[0] <= bus.rd_uram;
    pa[0] <= bus.rd_addr;
  end
  assign bus.data_uram = pv[RD_LAT-1] ? mem_word(pa[RD_LAT-1], mem_salt) : ~mem_word(pa[RD_LAT-1], mem_salt);

  typedef struct { int cyc; bit id; logic [URAM_ADDR-1:0] addr; } gnt_t;
  typedef struct { int cyc; logic v0; logic v1; logic p; logic r0; logic r1; logic busy; } vec_t;
  typedef struct { int cyc; bit id; logic [WIDTH-1:0] data; } rsp_t;

  gnt_t glog[$];
  gnt_t rdlog[$];
  vec_t vlog[$];
  rsp_t rsplog[$];
  logic [URAM_ADDR-1:0] src0[$];
  logic [URAM_ADDR-1:0] src1[$];

  always @(negedge clk) begin
    if (!rst) begin
      vlog.push_back('{cyc, bus.req0_valid, bus.req1_valid, bus.pause, bus.req0_ready, bus.req1_ready, bus.busy});
      if (bus.req0_valid && bus.req0_ready) glog.push_back('{cyc, 1'b0, bus.req0_addr});
      if (bus.req1_valid && bus.req1_ready) glog.push_back('{cyc, 1'b1, bus.req1_addr});
      if (bus.rd_uram) rdlog.push_back('{cyc, 1'b0, bus.rd_addr});
      if (bus.rsp0_valid) rsplog.push_back('{cyc, 1'b0, bus.rsp0_data});
      if (bus.rsp1_valid) rsplog.push_back('{cyc, 1'b1, bus.rsp1_data});
    end
  end

  task automatic clear_logs();
    glog.delete();
    rdlog.delete();
    vlog.delete();
    rsplog.delete();
  endtask

  task automatic pulse_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    bus.pause = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    clear_logs();
  endtask

  // Requesters pop addresses from src0/src1, holding valid until accepted.
  // Pause is raised for pause_len cycles after the pause_after-th accept.
  task automatic run_traffic(input int budget, input int idle_pct, input int pause_after, input int pause_len);
    bit h0 = 0;
    bit h1 = 0;
    bit acc_now;
    int acc = 0;
    int pause_left = 0;
    int n = 0;
    while (1) begin
      @(posedge clk); #1;
      bus.pause = (pause_left > 0);
      if (pause_left > 0) pause_left--;
      if (!h0) begin
        bus.req0_valid = (src0.size() > 0) && ($urandom_range(99) >= idle_pct);
        bus.req0_addr  = bus.req0_valid ? src0[0] : URAM_ADDR'($urandom);
      end
      if (!h1) begin
        bus.req1_valid = (src1.size() > 0) && ($urandom_range(99) >= idle_pct);
        bus.req1_addr  = bus.req1_valid ? src1[0] : URAM_ADDR'($urandom);
      end
      @(negedge clk); #1;
      acc_now = 0;
      if (bus.req0_valid && bus.req0_ready) begin
        void'(src0.pop_front());
        h0 = 0; acc_now = 1; acc++;
        if (acc == pause_after) pause_left = pause_len;
      end else h0 = bus.req0_valid;
      if (bus.req1_valid && bus.req1_ready) begin
        void'(src1.pop_front());
        h1 = 0; acc_now = 1; acc++;
        if (acc == pause_after) pause_left = pause_len;
      end else h1 = bus.req1_valid;
      n++;
      if (!acc_now && !h0 && !h1 && src0.size() == 0 && src1.size() == 0 && !bus.busy) break;
      if (n >= budget) begin
        total++; bad++;
        $display("FAIL traffic_timeout: cycles=%0d pending=%0d", n, src0.size() + src1.size());
        break;
      end
    end
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    bus.pause = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.pause = 1'b0;
    bus.req0_valid = 1'b1; bus.req0_addr = 12'h001;
    bus.req1_valid = 1'b1; bus.req1_addr = 12'h002;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++;
    if ({bus.req0_ready, bus.req1_ready} !== 2'b00) begin
      bad++; $display("FAIL reset_ready: got %b want 00", {bus.req0_ready, bus.req1_ready});
    end
    total++;
    if (bus.rd_uram !== 1'b0 || bus.rd_addr !== '0) begin
      bad++; $display("FAIL reset_rd: got rd=%b addr=%h want rd=0 addr=000", bus.rd_uram, bus.rd_addr);
    end
    total++;
    if ({bus.rsp0_valid, bus.rsp1_valid} !== 2'b00) begin
      bad++; $display("FAIL reset_rsp_valid: got %b want 00", {bus.rsp0_valid, bus.rsp1_valid});
    end
    total++;
    if (bus.rsp0_data !== '0 || bus.rsp1_data !== '0) begin
      bad++; $display("FAIL reset_rsp_data: got low words %h %h want 0", bus.rsp0_data[31:0], bus.rsp1_data[31:0]);
    end
    total++;
    if (bus.busy !== 1'b0) begin
      bad++; $display("FAIL reset_busy: got %b want 0", bus.busy);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    clear_logs();
  endtask

  task automatic test_single();
    clear_logs();
    src0.push_back(12'h005);
    run_traffic(50, 0, 0, 0);
    total++;
    if (glog.size() !== 1 || rdlog.size() !== 1 || rsplog.size() !== 1) begin
      bad++; $display("FAIL single_counts: got g=%0d rd=%0d rsp=%0d want 1 1 1", glog.size(), rdlog.size(), rsplog.size());
    end else begin
      total++;
      if (rdlog[0].cyc !== glog[0].cyc + 1 || rdlog[0].addr !== 12'h005) begin
        bad++; $display("FAIL single_rd: got cyc+%0d addr=%h want cyc+1 addr=005", rdlog[0].cyc - glog[0].cyc, rdlog[0].addr);
      end
      total++;
      if (rsplog[0].cyc !== glog[0].cyc + RD_LAT + 2 || rsplog[0].id !== 1'b0) begin
        bad++; $display("FAIL single_rsp_timing: got lat=%0d port=%0d want lat=%0d port=0", rsplog[0].cyc - glog[0].cyc, rsplog[0].id, RD_LAT + 2);
      end
      total++;
      if (rsplog[0].data !== mem_word(12'h005, mem_salt)) begin
        bad++; $display("FAIL single_rsp_data: got %h want %h", rsplog[0].data[31:0], mem_word(12'h005, mem_salt)[31:0]);
      end
    end
  endtask

  task automatic test_contention();
    bit eid;
    pulse_reset();
    for (int i = 0; i < 4; i++) begin
      src0.push_back(12'h010);
      src1.push_back(12'h020);
    end
    run_traffic(80, 0, 0, 0);
    total++;
    if (glog.size() !== 8 || rsplog.size() !== 8 || rdlog.size() !== 8) begin
      bad++; $display("FAIL contention_counts: got g=%0d rd=%0d rsp=%0d want 8", glog.size(), rdlog.size(), rsplog.size());
    end else begin
      for (int i = 0; i < 8; i++) begin
        eid = 1'(i % 2);
        total++;
        if (glog[i].id !== eid || glog[i].cyc !== glog[0].cyc + i || rdlog[i].addr !== (eid ? 12'h020 : 12'h010)) begin
          bad++; $display("FAIL contention_grant%0d: got id=%0d dcyc=%0d addr=%h want id=%0d dcyc=%0d", i, glog[i].id, glog[i].cyc - glog[0].cyc, rdlog[i].addr, eid, i);
        end
        total++;
        if (rsplog[i].id !== eid || rsplog[i].cyc !== glog[i].cyc + RD_LAT + 2 || rsplog[i].data !== mem_word(eid ? 12'h020 : 12'h010, mem_salt)) begin
          bad++; $display("FAIL contention_rsp%0d: got id=%0d lat=%0d data=%h want id=%0d lat=%0d", i, rsplog[i].id, rsplog[i].cyc - glog[i].cyc, rsplog[i].data[31:0], eid, RD_LAT + 2);
        end
      end
    end
  endtask

  task automatic test_streaming();
    clear_logs();
    for (int i = 0; i < 8; i++) src1.push_back(URAM_ADDR'(i));
    run_traffic(80, 0, 0, 0);
    total++;
    if (glog.size() !== 8 || rsplog.size() !== 8) begin
      bad++; $display("FAIL stream_counts: got g=%0d rsp=%0d want 8 8", glog.size(), rsplog.size());
    end else begin
      for (int i = 0; i < 8; i++) begin
        total++;
        if (glog[i].id !== 1'b1 || glog[i].cyc !== glog[0].cyc + i) begin
          bad++; $display("FAIL stream_accept%0d: got id=%0d dcyc=%0d want id=1 dcyc=%0d", i, glog[i].id, glog[i].cyc - glog[0].cyc, i);
        end
        total++;
        if (rsplog[i].id !== 1'b1 || rsplog[i].cyc !== glog[0].cyc + i + RD_LAT + 2 || rsplog[i].data !== mem_word(URAM_ADDR'(i), mem_salt)) begin
          bad++; $display("FAIL stream_rsp%0d: got id=%0d dcyc=%0d data=%h want id=1 dcyc=%0d data=%h", i, rsplog[i].id, rsplog[i].cyc - glog[0].cyc, rsplog[i].data[31:0], i + RD_LAT + 2, mem_word(URAM_ADDR'(i), mem_salt)[31:0]);
        end
      end
    end
  endtask

  task automatic test_pause();
    localparam int PLEN = 12;
    logic [URAM_ADDR-1:0] addrs[$];
    int early;
    int vi;
    clear_logs();
    for (int i = 0; i < 8; i++) begin
      addrs.push_back(URAM_ADDR'($urandom));
      src0.push_back(addrs[i]);
    end
    run_traffic(120, 0, 3, PLEN);
    total++;
    if (glog.size() !== 8 || rsplog.size() !== 8) begin
      bad++; $display("FAIL pause_counts: got g=%0d rsp=%0d want 8 8", glog.size(), rsplog.size());
    end else begin
      total++;
      if (glog[3].cyc - glog[2].cyc !== PLEN + 1 || glog[3].addr !== addrs[3]) begin
        bad++; $display("FAIL pause_resume: got gap=%0d addr=%h want gap=%0d addr=%h", glog[3].cyc - glog[2].cyc, glog[3].addr, PLEN + 1, addrs[3]);
      end
      for (int i = 0; i < vlog.size(); i++) begin
        if (vlog[i].p === 1'b1) begin
          total++;
          if ({vlog[i].r0, vlog[i].r1} !== 2'b00) begin
            bad++; $display("FAIL pause_ready: cyc=%0d got %b want 00", vlog[i].cyc, {vlog[i].r0, vlog[i].r1});
          end
        end
      end
      early = 0;
      foreach (rsplog[i]) if (rsplog[i].cyc < glog[3].cyc) early++;
      total++;
      if (early !== 3) begin
        bad++; $display("FAIL pause_drain: got %0d responses while paused want 3", early);
      end
      vi = rsplog[2].cyc - vlog[0].cyc;
      total++;
      if (vi < 0 || vi + 1 >= vlog.size() || vlog[vi].busy !== 1'b1 || vlog[vi+1].busy !== 1'b0) begin
        bad++; $display("FAIL pause_busy: got busy at last rsp/after = %b%b want 10", (vi >= 0 && vi < vlog.size()) ? vlog[vi].busy : 1'bx, (vi >= 0 && vi + 1 < vlog.size()) ? vlog[vi+1].busy : 1'bx);
      end
      for (int i = 0; i < 8; i++) begin
        total++;
        if (rsplog[i].id !== 1'b0 || rsplog[i].data !== mem_word(addrs[i], mem_salt)) begin
          bad++; $display("FAIL pause_rsp%0d: got id=%0d data=%h want id=0 data=%h", i, rsplog[i].id, rsplog[i].data[31:0], mem_word(addrs[i], mem_salt)[31:0]);
        end
      end
    end
  endtask

  task automatic test_reset_midflight();
    clear_logs();
    @(posedge clk); #1;
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b1; bus.req1_addr = 12'h123;
    @(posedge clk); #1;
    bus.req1_valid = 1'b0;
    bus.req0_valid = 1'b1; bus.req0_addr = 12'h456;
    @(posedge clk); #1;
    bus.req0_valid = 1'b0;
    // Reset lands in the cycle just before the first response would appear.
    repeat (RD_LAT - 1) @(posedge clk);
    #1;
    rst = 1'b1;
    bus.req0_valid = 1'b1;
    bus.req1_valid = 1'b1;
    @(negedge clk);
    total++;
    if ({bus.req0_ready, bus.req1_ready} !== 2'b00) begin
      bad++; $display("FAIL midrst_ready: got %b want 00", {bus.req0_ready, bus.req1_ready});
    end
    @(posedge clk); #1;
    rst = 1'b0;
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    mem_salt = $urandom;
    repeat (RD_LAT + 4) @(posedge clk);
    @(negedge clk);
    total++;
    if (glog.size() !== 2 || glog[0].id !== 1'b1 || glog[1].id !== 1'b0) begin
      bad++; $display("FAIL midrst_pre_grants: got %0d grants want 2 (ids 1,0)", glog.size());
    end
    total++;
    if (rsplog.size() !== 0) begin
      bad++; $display("FAIL midrst_no_rsp: got %0d responses want 0", rsplog.size());
    end
    total++;
    if (bus.rd_uram !== 1'b0 || bus.rd_addr !== '0 || bus.busy !== 1'b0 || bus.rsp0_data !== '0 || bus.rsp1_data !== '0) begin
      bad++; $display("FAIL midrst_outputs: got rd=%b addr=%h busy=%b d0=%h d1=%h want all 0", bus.rd_uram, bus.rd_addr, bus.busy, bus.rsp0_data[31:0], bus.rsp1_data[31:0]);
    end
    @(posedge clk); #1;
    bus.req0_valid = 1'b1; bus.req0_addr = 12'h0AA;
    bus.req1_valid = 1'b1; bus.req1_addr = 12'h0BB;
    @(negedge clk);
    total++;
    if ({bus.req0_ready, bus.req1_ready} !== 2'b10) begin
      bad++; $display("FAIL midrst_first_contention: got %b want 10", {bus.req0_ready, bus.req1_ready});
    end
    @(posedge clk); #1;
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    repeat (RD_LAT + 4) @(posedge clk);
  endtask

  task automatic test_boundary();
    pulse_reset();
    src0.push_back(12'hFFF);
    src1.push_back(12'h000);
    run_traffic(50, 0, 0, 0);
    total++;
    if (glog.size() !== 2 || rdlog.size() !== 2 || rsplog.size() !== 2 || glog[0].id !== 1'b0 || glog[1].id !== 1'b1) begin
      bad++; $display("FAIL boundary_grants: got g=%0d rd=%0d rsp=%0d want 2 2 2, req0 first", glog.size(), rdlog.size(), rsplog.size());
    end else begin
      total++;
      if (rdlog[0].addr !== 12'hFFF || rdlog[1].addr !== 12'h000) begin
        bad++; $display("FAIL boundary_rd_addr: got %h %h want fff 000", rdlog[0].addr, rdlog[1].addr);
      end
      total++;
      if (rsplog[0].id !== 1'b0 || rsplog[0].data !== mem_word(12'hFFF, mem_salt) ||
          rsplog[1].id !== 1'b1 || rsplog[1].data !== mem_word(12'h000, mem_salt)) begin
        bad++; $display("FAIL boundary_rsp: got ids %0d %0d data %h %h", rsplog[0].id, rsplog[1].id, rsplog[0].data[31:0], rsplog[1].data[31:0]);
      end
    end
  endtask

  task automatic test_random();
    bit lg;
    bit e0;
    bit e1;
    pulse_reset();
    for (int i = 0; i < 20; i++) begin
      src0.push_back(URAM_ADDR'($urandom));
      src1.push_back(URAM_ADDR'($urandom));
    end
    run_traffic(400, 35, int'($urandom_range(15, 5)), int'($urandom_range(6, 1)));
    // Round-robin rule: lone requester wins; on a tie the one that was not granted last wins.
    lg = 1'b1;
    for (int i = 0; i < vlog.size(); i++) begin
      e0 = !vlog[i].p && vlog[i].v0 && (!vlog[i].v1 || lg);
      e1 = !vlog[i].p && vlog[i].v1 && (!vlog[i].v0 || !lg);
      total++;
      if ({vlog[i].r0, vlog[i].r1} !== {e0, e1}) begin
        bad++; $display("FAIL random_grant: cyc=%0d got %b%b want %b%b", vlog[i].cyc, vlog[i].r0, vlog[i].r1, e0, e1);
      end
      if (e0) lg = 1'b0;
      if (e1) lg = 1'b1;
    end
    total++;
    if (glog.size() !== 40 || rdlog.size() !== 40 || rsplog.size() !== 40) begin
      bad++; $display("FAIL random_counts: got g=%0d rd=%0d rsp=%0d want 40", glog.size(), rdlog.size(), rsplog.size());
    end
    for (int i = 0; i < glog.size(); i++) begin
      if (i < rdlog.size()) begin
        total++;
        if (rdlog[i].cyc !== glog[i].cyc + 1 || rdlog[i].addr !== glog[i].addr) begin
          bad++; $display("FAIL random_rd%0d: got dcyc=%0d addr=%h want dcyc=1 addr=%h", i, rdlog[i].cyc - glog[i].cyc, rdlog[i].addr, glog[i].addr);
        end
      end
      if (i < rsplog.size()) begin
        total++;
        if (rsplog[i].cyc !== glog[i].cyc + RD_LAT + 2 || rsplog[i].id !== glog[i].id || rsplog[i].data !== mem_word(glog[i].addr, mem_salt)) begin
          bad++; $display("FAIL random_rsp%0d: got lat=%0d id=%0d data=%h want lat=%0d id=%0d data=%h", i, rsplog[i].cyc - glog[i].cyc, rsplog[i].id, rsplog[i].data[31:0], RD_LAT + 2, glog[i].id, mem_word(glog[i].addr, mem_salt)[31:0]);
        end
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time=%0t limit reached", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.pause = 1'b0;
    bus.req0_valid = 1'b0;
    bus.req0_addr = '0;
    bus.req1_valid = 1'b0;
    bus.req1_addr = '0;
    test_reset();
    test_single();
    test_contention();
    test_streaming();
    test_pause();
    test_reset_midflight();
    test_boundary();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uram_read_arbiter.md
Name: uram_read_arbiter

Overview:
- Shares the single template-URAM read port (rd_uram / rd_addr / data_uram) between two independent read requesters, e.g. two exponent scanners feeding separate SyncFIFOs.
- Grants one request per cycle with round-robin fairness and issues a registered read to the URAM.
- Tracks each in-flight read through a tag pipeline matched to the URAM read latency, and routes the returned word to the requester that issued it.

Parameters:
- WIDTH, 3072: data word width of the URAM template table.
- URAM_ADDR, 12: URAM address width.
- RD_LAT, 2: cycles from rd_uram sampled high to the matching data valid on data_uram; legal range 1..8.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous reset, active-high.
- pause  input  1  when high, no new grants; in-flight reads drain normally.
- req0_valid  input  1  requester 0 has a read address.
- req0_addr  input  URAM_ADDR  requester 0 read address.
- req0_ready  output  1  requester 0 accepted this cycle (combinational grant).
- rsp0_valid  output  1  one-cycle pulse: rsp0_data valid.
- rsp0_data  output  WIDTH  returned word for requester 0.
- req1_valid  input  1  requester 1 has a read address.
- req1_addr  input  URAM_ADDR  requester 1 read address.
- req1_ready  output  1  requester 1 accepted this cycle.
- rsp1_valid  output  1  one-cycle pulse: rsp1_data valid.
- rsp1_data  output  WIDTH  returned word for requester 1.
- rd_uram  output  1  URAM read enable (registered).
- rd_addr  output  URAM_ADDR  URAM read address (registered).
- data_uram  input  WIDTH  URAM read data, valid RD_LAT cycles after rd_uram.
- busy  output  1  high while any read is in flight or rsp*_valid is high.

Behaviour:
- Interface: single clock clk; reset rst is synchronous and active-high.
- Handshake: request N is accepted in cycle T when reqN_valid && reqN_ready. reqN_ready is combinational from valids, pause, last_grant and rst. No more than one ready is high per cycle. Requesters hold valid/addr stable until accepted.
- Grant rules, evaluated every cycle:
  - rst or pause high: neither ready.
  - Only one valid: grant that requester.
  - Both valid: grant the requester != last_grant.
  - last_grant updates to the granted index on accept. Reset value is 1, so requester 0 wins the first contention.
- Issue: accept in cycle T registers rd_uram=1 and rd_addr=accepted address, visible in cycle T+1. With no accept, rd_uram=0 and rd_addr holds its last value.
- Tag pipeline: shift register of RD_LAT+1 stages, each holding {valid, id}. It is loaded on accept and shifted every cycle, unconditionally.
- Return: when the final tag stage is valid (cycle T+1+RD_LAT), data_uram is captured into rsp{id}_data and rsp{id}_valid pulses high in cycle T+2+RD_LAT.
  - Total latency from accept to response: RD_LAT+2 cycles.
  - The other response port's valid stays 0; its data holds its previous value.
- Throughput: one accept per cycle sustained. Responses return in accept order with no stall; requesters must always absorb responses (no rsp ready).
- pause rising mid-stream: the accept in the same cycle is blocked, while issued reads still complete. busy falls the cycle after the last rsp pulse.
- busy = OR of all tag valid bits OR rsp0_valid OR rsp1_valid.
- Address range: full 0..2^URAM_ADDR-1 passed unmodified; no wrap or offset logic.
- Reset, applied any cycle including mid-flight:
  - Registers cleared: rd_uram=0, rd_addr=0, rsp0_valid=rsp1_valid=0, rsp0_data=rsp1_data=0, all tag valids=0, last_grant=1, busy=0.
  - Reads in flight at reset produce no response, even if data_uram later changes.
  - Readies are 0 while rst is high.

Test Plan:
- Single read: req0_valid with addr 0x005 at cycle 10, RD_LAT=2 -> req0_ready=1 at 10; rd_uram=1, rd_addr=0x005 at 11; rsp0_valid pulse at 14 with URAM[5]; rsp1_valid stays 0.
- Contention: both valid continuously from reset, addrs 0x010 and 0x020 -> grants alternate 0,1,0,1; rd_addr sequence 0x010,0x020,0x010,...; responses alternate ports at 1 per cycle.
- Streaming: req1 alone, addrs 0..7 back-to-back -> 8 consecutive accepts; rsp1_valid high 8 consecutive cycles, data URAM[0..7] in order.
- Pause: stream req0, assert pause after the 3rd accept -> ready=0 while paused; exactly 3 responses; busy low the cycle after the 3rd response; resuming continues from the 4th address.
- Reset mid-flight: 2 reads accepted, rst pulsed 1 cycle before the first response -> no rsp pulses; all outputs 0; the first post-reset contention grants requester 0.
- Boundary address: req0 addr 0xFFF, req1 addr 0x000 same cycle -> req0 granted first; rd_addr=0xFFF then 0x000; correct data routed to each port.
